// File: rtl/timer_bus.sv
// Memory-mapped interval timer: prescaled 32-bit counter with compare/auto-reload,
// sticky W1C status and registered interrupt. Define TIMER_PRESCALE_EN to build the prescaler.
module timer_bus #(
  parameter int          ADDR_W        = 5,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ack,
  output logic              timer_int
);

  logic [2:0]  ctrl;
  logic [31:0] count;
  logic [31:0] count_nxt;
  logic [31:0] compare;
  logic        match;
  logic        ovf;
  logic        tick;
  logic [31:0] prescale_rd;
  logic [31:0] rd_mux;
  logic [2:0]  sel;
  logic        access;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        cnt_eq_cmp;
  logic        cnt_max;
  logic        set_match;
  logic        set_ovf;
  logic        unused_addr;

  // A request arriving during the ack cycle is the tail of the previous access.
  assign access      = bus_req && !bus_ack;
  assign sel         = bus_addr[4:2];
  assign unused_addr = ^bus_addr[1:0];

  assign wr_ctrl    = access && bus_we && (sel == 3'd0);
  assign wr_count   = access && bus_we && (sel == 3'd2);
  assign wr_compare = access && bus_we && (sel == 3'd3);
  assign wr_status  = access && bus_we && (sel == 3'd4);

`ifdef TIMER_PRESCALE_EN
  logic [31:0] prescale;
  logic [31:0] pre_cnt;
  logic        wr_prescale;

  assign wr_prescale = access && bus_we && (sel == 3'd1);
  assign tick        = ctrl[0] && (pre_cnt == prescale);
  assign prescale_rd = prescale;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else begin
      if (wr_prescale) prescale <= bus_wdata;
      if (wr_prescale || wr_count) pre_cnt <= '0;
      else if (ctrl[0]) pre_cnt <= tick ? '0 : pre_cnt + 32'd1;
    end
  end
`else
  assign tick        = ctrl[0];
  assign prescale_rd = '0;
`endif

  assign cnt_eq_cmp = (count == compare);
  assign cnt_max    = &count;
  assign set_match  = tick && cnt_eq_cmp;
  // A match with auto-reload returns to 0 without wrapping, so it is not an overflow.
  assign set_ovf    = tick && cnt_max && !(cnt_eq_cmp && ctrl[1]);

  always_comb begin
    count_nxt = count;
    if (wr_count) begin
      count_nxt = bus_wdata;
    end else if (tick) begin
      if (cnt_eq_cmp && ctrl[1]) count_nxt = '0;
      else count_nxt = count + 32'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      3'd0:    rd_mux = {29'd0, ctrl};
      3'd1:    rd_mux = prescale_rd;
      3'd2:    rd_mux = count;
      3'd3:    rd_mux = compare;
      3'd4:    rd_mux = {30'd0, ovf, match};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      ctrl      <= '0;
      count     <= '0;
      compare   <= RESET_COMPARE;
      match     <= 1'b0;
      ovf       <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      bus_ack   <= access;
      bus_rdata <= (access && !bus_we) ? rd_mux : '0;
      if (wr_ctrl) ctrl <= bus_wdata[2:0];
      if (wr_compare) compare <= bus_wdata;
      count     <= count_nxt;
      match     <= set_match | (match & ~(wr_status & bus_wdata[0]));
      ovf       <= set_ovf | (ovf & ~(wr_status & bus_wdata[1]));
      timer_int <= ctrl[2] & (match | ovf);
    end
  end

endmodule

// File: tb/tb_timer_bus.sv
// Scoreboard bench for timer_bus: the driver queues the expected response of each
// access, a monitor pops and compares on every bus_ack.
module tb_timer_bus;

  logic        clk;
  logic        rst;
  logic        bus_req;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        timer_int;

  localparam logic [4:0] A_CTRL = 5'h00;
  localparam logic [4:0] A_PRE  = 5'h04;
  localparam logic [4:0] A_CNT  = 5'h08;
  localparam logic [4:0] A_CMP  = 5'h0C;
  localparam logic [4:0] A_STAT = 5'h10;

`ifdef TIMER_PRESCALE_EN
  localparam int          P     = 4;
  localparam logic [31:0] PS_RB = 32'h7;
`else
  localparam int          P     = 1;
  localparam logic [31:0] PS_RB = 32'h0;
`endif
  localparam int M = 3 * P;

  typedef struct {
    logic [31:0] exp;
    string       nm;
  } sb_t;

  sb_t sbq[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  timer_bus #(.ADDR_W(5), .RESET_COMPARE(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .timer_int(timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry; outside acks rdata must be 0.
  always @(negedge clk) begin
    sb_t t;
    if (bus_ack === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: ack with no access outstanding (cycle %0d)", cyc);
      end else begin
        t = sbq.pop_front();
        check(t.nm, bus_rdata, t.exp);
      end
    end else if (cyc > 0) begin
      check("rdata_idle", bus_rdata, 32'h0);
    end
  end

  // Called at a negedge; the request is sampled at the next posedge.
  task automatic issue(input bit we, input logic [4:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input string nm);
    sb_t t;
    t.exp = we ? 32'h0 : exp;
    t.nm  = nm;
    sbq.push_back(t);
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus_req = 1'b0;
    bus_we  = 1'b0;
    #1;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_latency: ack not seen 1 cycle after req, got %0d pending, expected 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Sample the access at posedge number e.
  task automatic access_at(input int e, input bit we, input logic [4:0] a,
                           input logic [31:0] wd, input logic [31:0] exp, input string nm);
    if (cyc > e - 1) begin
      n_fail++;
      $display("FAIL %s_sched: at cycle %0d, expected to issue by cycle %0d", nm, cyc, e - 1);
    end
    wait_to(e - 1);
    issue(we, a, wd, exp, nm);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, output int e);
    @(negedge clk);
    e = cyc + 1;
    issue(1'b1, a, d, 32'h0, "wr");
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    issue(1'b0, a, 32'h0, exp, nm);
  endtask

  int e;
  int k;

  initial begin
    rst = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_int", {31'd0, timer_int}, 32'h0);
    check("rst_ack", {31'd0, bus_ack}, 32'h0);
    rst = 1'b1;
    rd(A_CTRL, 32'h0, "idle_ctrl");
    rd(A_PRE,  32'h0, "idle_pre");
    rd(A_CNT,  32'h0, "idle_cnt");
    rd(A_CMP,  32'hFFFF_FFFF, "idle_cmp");
    rd(A_STAT, 32'h0, "idle_stat");
    for (int i = 5; i < 8; i++) rd(5'(i * 4), 32'h0, "idle_rsvd");
    wr(A_PRE, 32'h7, e);
    rd(A_PRE, PS_RB, "pre_rb");
    wr(5'h14, 32'hDEAD_BEEF, e);
    rd(5'h14, 32'h0, "rsvd_wr");

    // Auto-reload interrupt, period 10
    wr(A_PRE, 32'h0, e);
    wr(A_CMP, 32'd9, e);
    wr(A_CTRL, 32'h7, e);
    wait_to(e + 10);
    check("auto_int_pre", {31'd0, timer_int}, 32'h0);
    wait_to(e + 11);
    check("auto_int_rise", {31'd0, timer_int}, 32'h1);
    access_at(e + 13, 1'b0, A_STAT, 32'h0, 32'h1, "auto_stat");
    for (int j = 15; j <= 21; j += 2)
      access_at(e + j, 1'b0, A_CNT, 32'h0, 32'((j - 1) % 10), "auto_cnt");

    // Prescale
    wr(A_CTRL, 32'h0, e);
    wr(A_STAT, 32'h3, e);
    wr(A_CNT, 32'h0, e);
    wr(A_CMP, 32'd2, e);
    wr(A_PRE, 32'd3, e);
    wr(A_CTRL, 32'h7, e);
    access_at(e + 2, 1'b0, A_CNT, 32'h0, 32'(((2 - 1) / P) % 3), "ps_cnt_early");
    wait_to(e + M);
    check("ps_int_pre", {31'd0, timer_int}, 32'h0);
    wait_to(e + M + 1);
    check("ps_int_rise", {31'd0, timer_int}, 32'h1);
    access_at(e + M + 3, 1'b0, A_STAT, 32'h0, 32'h1, "ps_stat");
    k = M + 5;
    access_at(e + k, 1'b0, A_CNT, 32'h0, 32'(((k - 1) / P) % 3), "ps_cnt_late");

    // Overflow
    wr(A_CTRL, 32'h0, e);
    wr(A_STAT, 32'h3, e);
    wr(A_PRE, 32'h0, e);
    wr(A_CMP, 32'd5, e);
    wr(A_CNT, 32'hFFFF_FFFE, e);
    wr(A_CTRL, 32'h5, e);
    access_at(e + 3, 1'b0, A_CNT, 32'h0, 32'h0, "ovf_cnt");
    access_at(e + 5, 1'b0, A_STAT, 32'h0, 32'h2, "ovf_stat");
    access_at(e + 7, 1'b1, A_STAT, 32'h2, 32'h0, "ovf_clr");
    check("ovf_int_hold", {31'd0, timer_int}, 32'h1);
    wait_to(e + 8);
    check("ovf_int_fall", {31'd0, timer_int}, 32'h0);
    access_at(e + 10, 1'b0, A_STAT, 32'h0, 32'h1, "ovf_stat_match");

    // Collisions
    wr(A_CTRL, 32'h0, e);
    wr(A_STAT, 32'h3, e);
    wr(A_CNT, 32'h0, e);
    wr(A_CMP, 32'd3, e);
    wr(A_CTRL, 32'h3, e);
    access_at(e + 4, 1'b1, A_STAT, 32'h1, 32'h0, "col_clr");
    access_at(e + 6, 1'b0, A_STAT, 32'h0, 32'h1, "col_set_wins");
    access_at(e + 9, 1'b1, A_STAT, 32'h1, 32'h0, "col_clr2");
    access_at(e + 11, 1'b0, A_STAT, 32'h0, 32'h0, "col_cleared");
    access_at(e + 13, 1'b1, A_CNT, 32'h100, 32'h0, "col_cnt_wr");
    access_at(e + 15, 1'b0, A_CNT, 32'h0, 32'h101, "col_cnt_rb");

    // Reset with a read pending and the timer running
    wr(A_CMP, 32'd9, e);
    wr(A_CTRL, 32'h7, e);
    repeat (12) @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = A_CNT; rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ack", {31'd0, bus_ack}, 32'h0);
    check("rst_mid_int", {31'd0, timer_int}, 32'h0);
    bus_req = 1'b0;
    rst = 1'b1;
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_PRE,  32'h0, "rst_pre");
    rd(A_CNT,  32'h0, "rst_cnt");
    rd(A_CMP,  32'hFFFF_FFFF, "rst_cmp");
    rd(A_STAT, 32'h0, "rst_stat");

    repeat (2) @(negedge clk);
    check("sb_drain", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
